// File: rtl/memory_arbiter_if.sv
// Wishbone-style bus bundle shared by the two requesters and the memory slave.
// The master drives the request fields; the slave returns data, ack and err.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_mosi,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_mosi,
    output dat_r, ack, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch/memory stage) round-robin arbiter onto a single memory slave.
// Optional busy timeout is enabled with the ARBITER_TIMEOUT_EN macro.
//
// state | meaning
// IDLE  | no grant; mem_wb outputs held at 0, waiting for a valid latch
// BUSY  | owner's latched request driven on mem_wb until ack/err (or timeout)
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  wishbone_interface.slave  instr_wb,
  wishbone_interface.slave  data_wb,
  wishbone_interface.master mem_wb
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {INSTR, DATA} port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  state_e state_q, state_d;
  port_e  owner_q, owner_d;
  port_e  last_q, last_d;
  logic   i_vld_q, i_vld_d;
  logic   d_vld_q, d_vld_d;
  req_t   i_req_q, d_req_q;
  req_t   cur_req;
  logic   i_new, d_new;
  logic   busy, done, timeout_hit;
  logic   resp_ack, resp_err;

  assign i_new = instr_wb.cyc && instr_wb.stb && !i_vld_q;
  assign d_new = data_wb.cyc  && data_wb.stb  && !d_vld_q;

  // Gating with rst keeps every output quiet during the reset cycle itself.
  assign busy = (state_q == BUSY) && !rst;
  assign done = busy && (mem_wb.ack || mem_wb.err || timeout_hit);

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = busy && !mem_wb.ack && !mem_wb.err && (tmo_cnt_q == TMO_LAST);
  assign tmo_cnt_d   = (state_q == BUSY && state_d == BUSY) ? tmo_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= 8'd0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= INSTR;
      last_q  <= INSTR;
      i_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      i_req_q <= '0;
      d_req_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      i_vld_q <= i_vld_d;
      d_vld_q <= d_vld_d;
      if (i_new) i_req_q <= '{instr_wb.we, instr_wb.adr, instr_wb.sel, instr_wb.dat_mosi};
      if (d_new) d_req_q <= '{data_wb.we, data_wb.adr, data_wb.sel, data_wb.dat_mosi};
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    i_vld_d = i_vld_q | i_new;
    d_vld_d = d_vld_q | d_new;
    case (state_q)
      IDLE: begin
        if (i_vld_q && d_vld_q) begin
          owner_d = (last_q == INSTR) ? DATA : INSTR;
          last_d  = owner_d;
          state_d = BUSY;
        end else if (i_vld_q) begin
          owner_d = INSTR;
          last_d  = INSTR;
          state_d = BUSY;
        end else if (d_vld_q) begin
          owner_d = DATA;
          last_d  = DATA;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          if (owner_q == DATA) d_vld_d = 1'b0;
          else                 i_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_req = (owner_q == DATA) ? d_req_q : i_req_q;

  assign mem_wb.cyc      = busy;
  assign mem_wb.stb      = busy;
  assign mem_wb.we       = busy & cur_req.we;
  assign mem_wb.adr      = busy ? cur_req.adr : 32'h0;
  assign mem_wb.sel      = busy ? cur_req.sel : 4'h0;
  assign mem_wb.dat_mosi = busy ? cur_req.dat : 32'h0;

  // err dominates ack when the slave raises both.
  assign resp_err = mem_wb.err | timeout_hit;
  assign resp_ack = mem_wb.ack & ~resp_err;

  assign instr_wb.ack   = busy && (owner_q == INSTR) && resp_ack;
  assign instr_wb.err   = busy && (owner_q == INSTR) && resp_err;
  assign instr_wb.dat_r = (busy && owner_q == INSTR) ? mem_wb.dat_r : 32'h0;

  assign data_wb.ack    = busy && (owner_q == DATA) && resp_ack;
  assign data_wb.err    = busy && (owner_q == DATA) && resp_err;
  assign data_wb.dat_r  = (busy && owner_q == DATA) ? mem_wb.dat_r : 32'h0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: table-driven single transactions plus
// hand-written sequences for ties, no-overwrite, reset in flight and timeout.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_interface instr_if();
  wishbone_interface data_if();
  wishbone_interface mem_if();

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr_wb (instr_if),
    .data_wb  (data_if),
    .mem_wb   (mem_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          port;     // 0 = instr, 1 = data
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          delay;    // BUSY cycles before the slave responds
    logic        rack;
    logic        rerr;
    logic [31:0] rdata;
    logic        exp_ack;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic set_req(input bit port, input logic en, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (port == 1'b0) begin
      instr_if.cyc = en; instr_if.stb = en; instr_if.we = we;
      instr_if.adr = adr; instr_if.sel = sel; instr_if.dat_mosi = dat;
    end else begin
      data_if.cyc = en; data_if.stb = en; data_if.we = we;
      data_if.adr = adr; data_if.sel = sel; data_if.dat_mosi = dat;
    end
  endtask

  task automatic set_resp(input logic ack, input logic err, input logic [31:0] dat);
    mem_if.ack = ack; mem_if.err = err; mem_if.dat_r = dat;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_i_ack"}, 32'(instr_if.ack), 32'h0);
    chk({tag, "_i_err"}, 32'(instr_if.err), 32'h0);
    chk({tag, "_i_dat"}, instr_if.dat_r, 32'h0);
    chk({tag, "_d_ack"}, 32'(data_if.ack), 32'h0);
    chk({tag, "_d_err"}, 32'(data_if.err), 32'h0);
    chk({tag, "_d_dat"}, data_if.dat_r, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    step();
    step();
    mid();
    chk("rst_cyc", 32'(mem_if.cyc), 32'h0);
    chk("rst_adr", mem_if.adr, 32'h0);
    chk_quiet("rst");
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0,         0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 4'h3, 32'h1234_5678, 2, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0,         1, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 4'h1, 32'h0,         0, 1'b1, 1'b1, 32'h0000_55AA, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 4'hC, 32'hA5A5_A5A5, 3, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0};

    do_reset();

    // Single transactions from the table.
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = vecs[i];
      step();
      set_req(v.port, 1'b1, v.we, v.adr, v.sel, v.dat);
      mid();
      chk($sformatf("v%0d_c0_cyc", i), 32'(mem_if.cyc), 32'h0);
      step();
      set_req(v.port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_resp(1'b1, 1'b1, 32'hFFFF_FFFF);
      mid();
      chk($sformatf("v%0d_c1_cyc", i), 32'(mem_if.cyc), 32'h0);
      chk_quiet($sformatf("v%0d_idle_resp", i));
      step();
      set_resp(1'b0, 1'b0, 32'h0);
      mid();
      chk($sformatf("v%0d_c2_cyc", i), 32'(mem_if.cyc), 32'h1);
      chk($sformatf("v%0d_c2_stb", i), 32'(mem_if.stb), 32'h1);
      chk($sformatf("v%0d_adr", i), mem_if.adr, v.adr);
      chk($sformatf("v%0d_we", i), 32'(mem_if.we), 32'(v.we));
      chk($sformatf("v%0d_sel", i), 32'(mem_if.sel), 32'(v.sel));
      chk($sformatf("v%0d_dat", i), mem_if.dat_mosi, v.dat);
      for (int k = 0; k < v.delay; k++) begin
        step();
        mid();
        chk($sformatf("v%0d_wait%0d", i, k),
            {29'h0, mem_if.cyc, instr_if.ack | data_if.ack, instr_if.err | data_if.err}, 32'h4);
      end
      set_resp(v.rack, v.rerr, v.rdata);
      #1;
      chk($sformatf("v%0d_own_ack", i), 32'(v.port ? data_if.ack : instr_if.ack), 32'(v.exp_ack));
      chk($sformatf("v%0d_own_err", i), 32'(v.port ? data_if.err : instr_if.err), 32'(v.exp_err));
      chk($sformatf("v%0d_own_dat", i), v.port ? data_if.dat_r : instr_if.dat_r, v.rdata);
      chk($sformatf("v%0d_oth_resp", i),
          32'(v.port ? {instr_if.ack, instr_if.err} : {data_if.ack, data_if.err}), 32'h0);
      chk($sformatf("v%0d_oth_dat", i), v.port ? instr_if.dat_r : data_if.dat_r, 32'h0);
      step();
      set_resp(1'b0, 1'b0, 32'h0);
      mid();
      chk($sformatf("v%0d_done_cyc", i), 32'(mem_if.cyc), 32'h0);
      chk_quiet($sformatf("v%0d_done", i));
    end

    // Tie right after reset: data wins, instr follows two cycles after data's ack.
    do_reset();
    step();
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid();
    chk("tie_c1_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("tie_first_cyc", 32'(mem_if.cyc), 32'h1);
    chk("tie_first_adr", mem_if.adr, 32'h20);
    set_resp(1'b1, 1'b0, 32'h1111);
    #1;
    chk("tie_d_ack", 32'(data_if.ack), 32'h1);
    chk("tie_d_dat", data_if.dat_r, 32'h1111);
    chk("tie_i_ack0", 32'(instr_if.ack), 32'h0);
    chk("tie_i_dat0", instr_if.dat_r, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("tie_gap_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("tie_second_cyc", 32'(mem_if.cyc), 32'h1);
    chk("tie_second_adr", mem_if.adr, 32'h10);
    set_resp(1'b1, 1'b0, 32'h2222);
    #1;
    chk("tie_i_ack", 32'(instr_if.ack), 32'h1);
    chk("tie_i_dat", instr_if.dat_r, 32'h2222);
    chk("tie_d_ack0", 32'(data_if.ack), 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("tie_end_cyc", 32'(mem_if.cyc), 32'h0);

    // Reassertion while the latch is valid is ignored, including in the completion cycle.
    step();
    set_req(1'b1, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    step();
    set_req(1'b1, 1'b1, 1'b1, 32'h400, 4'h3, 32'hBAD);
    step();
    mid();
    chk("novw_cyc", 32'(mem_if.cyc), 32'h1);
    chk("novw_adr", mem_if.adr, 32'h300);
    chk("novw_we", 32'(mem_if.we), 32'h0);
    step();
    mid();
    chk("novw_adr2", mem_if.adr, 32'h300);
    set_resp(1'b1, 1'b0, 32'h3333);
    #1;
    chk("novw_ack", 32'(data_if.ack), 32'h1);
    step();
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("novw_m1_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("novw_m2_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("novw_m3_cyc", 32'(mem_if.cyc), 32'h0);

    // Round robin after a data grant: instr wins the tie; ack+err gives err only.
    step();
    set_req(1'b0, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    mid();
    chk("rr_first_adr", mem_if.adr, 32'h500);
    set_resp(1'b1, 1'b1, 32'h4444);
    #1;
    chk("rr_i_err", 32'(instr_if.err), 32'h1);
    chk("rr_i_ack", 32'(instr_if.ack), 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("rr_gap_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("rr_second_cyc", 32'(mem_if.cyc), 32'h1);
    chk("rr_second_adr", mem_if.adr, 32'h600);
    set_resp(1'b1, 1'b0, 32'h5555);
    #1;
    chk("rr_d_ack", 32'(data_if.ack), 32'h1);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("rr_end_cyc", 32'(mem_if.cyc), 32'h0);

    // Reset while BUSY with data owner and an instr request pending.
    step();
    set_req(1'b1, 1'b1, 1'b0, 32'h700, 4'hF, 32'h0);
    step();
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    mid();
    chk("rbusy_cyc", 32'(mem_if.cyc), 32'h1);
    chk("rbusy_adr", mem_if.adr, 32'h700);
    set_req(1'b0, 1'b1, 1'b0, 32'h800, 4'hF, 32'h0);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    set_resp(1'b1, 1'b0, 32'h6666);
    mid();
    chk("rbusy_in_rst_cyc", 32'(mem_if.cyc), 32'h0);
    chk_quiet("rbusy_in_rst");
    step();
    rst = 1'b0;
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("rbusy_after_cyc", 32'(mem_if.cyc), 32'h0);
    chk_quiet("rbusy_after");
    step();
    mid();
    chk("rbusy_after2_cyc", 32'(mem_if.cyc), 32'h0);
    step();
    mid();
    chk("rbusy_after3_cyc", 32'(mem_if.cyc), 32'h0);

    // Silent slave.
    step();
    set_req(1'b0, 1'b1, 1'b0, 32'h900, 4'hF, 32'h0);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
`ifdef ARBITER_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("tmo_wait%0d", k), {29'h0, mem_if.cyc, instr_if.ack, instr_if.err}, 32'h4);
      step();
    end
    mid();
    chk("tmo_err", 32'(instr_if.err), 32'h1);
    chk("tmo_ack", 32'(instr_if.ack), 32'h0);
    chk("tmo_cyc", 32'(mem_if.cyc), 32'h1);
    step();
    mid();
    chk("tmo_after_cyc", 32'(mem_if.cyc), 32'h0);
    chk_quiet("tmo_after");
`else
    for (int k = 0; k < 100; k++) begin
      mid();
      chk($sformatf("notmo_%0d", k), {29'h0, mem_if.cyc, instr_if.ack, instr_if.err}, 32'h4);
      step();
    end
    mid();
    set_resp(1'b1, 1'b0, 32'h7777);
    #1;
    chk("notmo_ack", 32'(instr_if.ack), 32'h1);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    mid();
    chk("notmo_end_cyc", 32'(mem_if.cyc), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, downstream busy-cycle limit before forced error; legal range 1..255; used only with ARBITER_TIMEOUT_EN.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: instr_wb  wishbone_interface.slave  bundle  fetch-stage requester; cyc, stb, we, adr[31:0], sel[3:0], dat_mosi[31:0] in; dat_r[31:0], ack, err out.
REQ-005 Port: data_wb  wishbone_interface.slave  bundle  memory-stage requester; same fields and directions as instr_wb.
REQ-006 Port: mem_wb  wishbone_interface.master  bundle  shared memory slave; cyc, stb, we, adr, sel, dat_mosi out; dat_r, ack, err in.

Function
REQ-007 Each port SHALL own a one-entry request latch (valid, we, adr, sel, dat_mosi) that captures on the edge closing any cycle where cyc&&stb is high and the latch is empty.
REQ-008 A requester SHALL have at most one outstanding request; cyc&&stb on a port whose latch is valid SHALL be ignored (no overwrite).
REQ-009 FSM states: IDLE, BUSY; owner register selects INSTR or DATA.
REQ-010 IDLE with exactly one valid latch: SHALL grant that port at the next edge (state BUSY, owner set).
REQ-011 IDLE with both latches valid: SHALL grant the port not granted last (round-robin); last_grant resets to INSTR, so DATA wins the first tie.
REQ-012 In BUSY, mem_wb cyc=stb=1 and we/adr/sel/dat_mosi SHALL be driven from the owner's latch; in IDLE all mem_wb outputs SHALL be 0.
REQ-013 Latency: request presented in cycle N -> mem_wb.cyc first high in cycle N+2 when the arbiter is IDLE with the other latch empty.
REQ-014 mem_wb.ack/err in BUSY cycle M SHALL be routed combinationally to the owner's ack/err in cycle M, with dat_r = mem_wb.dat_r; the owner's latch clears and state returns to IDLE at the end of M.
REQ-015 Non-owner ack/err SHALL be 0 and dat_r SHALL be 32'h0 at all times; in IDLE both ports' ack/err SHALL be 0.
REQ-016 Simultaneous mem_wb.ack and mem_wb.err: owner SHALL see err=1, ack=0.
REQ-017 mem_wb.ack/err while IDLE SHALL be ignored.
REQ-018 A port capturing a new request in the same cycle its response completes SHALL be impossible (latch still valid); the new request is captured from cycle M+1 onward.
REQ-019 Back-to-back: after completion in cycle M, a pending other-port request SHALL drive mem_wb.cyc from cycle M+2.

Reset
REQ-020 On rst high at a rising edge: state IDLE, both latches invalid, last_grant INSTR, timeout counter 0; in-flight transactions are dropped without ack/err.
REQ-021 During and after reset until a new grant: all mem_wb outputs 0, all port ack/err 0, port dat_r 32'h0.

Configuration
REQ-022 Macro ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL count BUSY cycles; in the BUSY cycle where it equals TIMEOUT_CYCLES-1 with no mem_wb ack/err, owner err SHALL be 1 that cycle, the latch clears, state returns to IDLE; counter clears on every entry to IDLE.
REQ-023 Macro undefined: no counter is implemented; BUSY lasts indefinitely until mem_wb ack/err; TIMEOUT_CYCLES has no effect.

Verification
REQ-024 instr_wb request adr=32'h100 at cycle 0, slave acks at its first cycle -> mem_wb.cyc cycle 2 with adr 32'h100, instr_wb.ack cycle 2 with dat_r = slave data, data_wb.ack stays 0.
REQ-025 Both ports request in cycle 0 right after reset -> data granted first (mem_wb.cyc cycle 2), instr granted second (mem_wb.cyc two cycles after data's ack).
REQ-026 Slave asserts ack and err together -> owner err=1, ack=0; latch clears; next queued request proceeds.
REQ-027 rst asserted while BUSY with data owner -> next cycle mem_wb.cyc=0, no ack/err on either port, both latches empty.
REQ-028 ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, silent slave -> owner err=1 in fourth BUSY cycle, mem_wb.cyc=0 next cycle; without macro -> mem_wb.cyc stays 1 for 100 cycles.
REQ-029 data_wb reasserts cyc&&stb with a different adr while its latch is valid -> ignored; mem_wb.adr keeps the originally latched value.
